// File: rtl/serializador_dac_pkg.sv
// Shared definitions for the serial DAC transmitter: state encoding,
// default frame geometry and the divider-width helper.
package serializador_dac_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        TRANSMITE = 2'd1,
        FIN       = 2'd2
    } estado_t;

    localparam int BITS_DEF = 16;
    localparam int DIV_DEF  = 2;

    // The divider counter needs at least one bit even when DIV is 1.
    function automatic int ancho_div(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/serializador_dac_if.sv
// Request side (inicio/dato, ocupado/listo) and DAC pins of the serializer.
interface serializador_dac_if #(
    parameter int BITS = serializador_dac_pkg::BITS_DEF
);
    logic            inicio;
    logic [BITS-1:0] dato;
    logic            sclk;
    logic            sync_n;
    logic            sdata;
    logic            ocupado;
    logic            listo;

    modport master (
        output inicio, dato,
        input  sclk, sync_n, sdata, ocupado, listo
    );

    modport slave (
        input  inicio, dato,
        output sclk, sync_n, sdata, ocupado, listo
    );
endinterface

// File: rtl/serializador_dac_registro.sv
// BITS-wide shift-left register with load (priority) and zero-filled shift.
module registro_desplazamiento #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            carga,
    input  logic            desplaza,
    input  logic [BITS-1:0] d,
    output logic            msb,
    output logic            siguiente
);
    logic [BITS-1:0] q_q;
    logic [BITS-1:0] q_d;

    // NOTE: q_d gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (carga) begin
            q_d = d;
        end else if (desplaza) begin
            q_d = {q_q[BITS-2:0], 1'b0};
        end
    end

    // NOTE: this is a plain register, not a memory array, so it is cleared with the rest of the block on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign msb       = q_q[BITS-1];
    // Bit that becomes the MSB after the next shift.
    assign siguiente = q_q[BITS-2];

endmodule

// File: rtl/serializador_dac.sv
// SPI-style DAC serializer: one MSB-first frame per accepted inicio,
// all pin outputs registered, completion flagged with a one-cycle listo.
module serializador_dac
    import serializador_dac_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int DIV  = DIV_DEF
) (
    input  logic               clk,
    input  logic               reset,
    serializador_dac_if.slave  bus
);
    localparam int BW = $clog2(BITS);
    localparam int DW = ancho_div(DIV);
    localparam logic [DW-1:0] DIV_FIN = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_INI = BW'(BITS - 1);

    estado_t       state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          sclk_q, sclk_d;
    logic          sync_n_q, sync_n_d;
    logic          sdata_q, sdata_d;
    logic          ocupado_q, ocupado_d;
    logic          listo_q, listo_d;

    logic          carga;
    logic          desplaza;
    logic          shift_msb;
    logic          shift_sig;

    registro_desplazamiento #(.BITS(BITS)) u_registro (
        .clk       (clk),
        .reset     (reset),
        .carga     (carga),
        .desplaza  (desplaza),
        .d         (bus.dato),
        .msb       (shift_msb),
        .siguiente (shift_sig)
    );

    // Pin values are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = 1'b1;
        sync_n_d  = 1'b1;
        sdata_d   = 1'b0;
        ocupado_d = 1'b0;
        listo_d   = 1'b0;
        carga     = 1'b0;
        desplaza  = 1'b0;

        case (state_q)
            TRANSMITE: begin
                sync_n_d  = 1'b0;
                ocupado_d = 1'b1;
                sclk_d    = sclk_q;
                sdata_d   = shift_msb;
                if (div_cnt_q != DIV_FIN) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == '0) begin
                        state_d  = FIN;
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        sdata_d  = 1'b0;
                        listo_d  = 1'b1;
                    end else begin
                        // New bit appears together with the rising sclk edge.
                        desplaza  = 1'b1;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        sclk_d    = 1'b1;
                        sdata_d   = shift_sig;
                    end
                end
            end
            FIN: begin
                state_d = REPOSO;
            end
            default: begin
                // REPOSO, and the unused code 2'd3 behaves the same.
                if (bus.inicio) begin
                    carga     = 1'b1;
                    state_d   = TRANSMITE;
                    bit_cnt_d = BIT_INI;
                    div_cnt_d = '0;
                    sync_n_d  = 1'b0;
                    ocupado_d = 1'b1;
                    sdata_d   = bus.dato[BITS-1];
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= REPOSO;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
            sync_n_q  <= 1'b1;
            sdata_q   <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            sdata_q   <= sdata_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.sync_n  = sync_n_q;
    assign bus.sdata   = sdata_q;
    assign bus.ocupado = ocupado_q;
    assign bus.listo   = listo_q;

endmodule

// File: tb/tb_serializador_dac.sv
// Directed bench for serializador_dac: a 16-bit/DIV=2 instance and a
// 12-bit/DIV=1 instance, each decoded by a falling-edge DAC model.
module tb_serializador_dac;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serializador_dac_if #(.BITS(16)) if0 ();
    serializador_dac_if #(.BITS(12)) if1 ();

    serializador_dac #(.BITS(16), .DIV(2)) u0 (.clk(clk), .reset(reset), .bus(if0));
    serializador_dac #(.BITS(12), .DIV(1)) u1 (.clk(clk), .reset(reset), .bus(if1));

    // Observes one instance for ncyc edges after the caller raised inicio.
    // Sample k is taken #1 after edge k and represents cycle T+k.
    task automatic capture(
        input  bit          sel,
        input  int          ncyc,
        input  int          hold_until,
        input  int          chg_at,
        input  logic [15:0] chg_val,
        input  int          rst_at,
        output logic [15:0] rx0,
        output logic [15:0] rx1,
        output int          nfr,
        output int          start1,
        output int          nbits0,
        output int          sync_low,
        output int          listo_cnt,
        output int          listo_first,
        output int          fall1,
        output int          fall2,
        output logic [4:0]  snap
    );
        logic p_sclk, p_sync, c_sclk, c_sync, c_sdata, c_ocup, c_listo;
        rx0 = '0; rx1 = '0; nfr = 0; start1 = 0; nbits0 = 0; sync_low = 0;
        listo_cnt = 0; listo_first = 0; fall1 = 0; fall2 = 0; snap = '0;
        p_sclk = 1'b1;
        p_sync = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            c_sclk  = sel ? if1.sclk    : if0.sclk;
            c_sync  = sel ? if1.sync_n  : if0.sync_n;
            c_sdata = sel ? if1.sdata   : if0.sdata;
            c_ocup  = sel ? if1.ocupado : if0.ocupado;
            c_listo = sel ? if1.listo   : if0.listo;
            if (p_sync && !c_sync) begin
                if (nfr == 1) start1 = k;
                nfr++;
            end
            if (p_sclk && !c_sclk) begin
                if (nfr == 1) begin
                    rx0 = {rx0[14:0], c_sdata};
                    nbits0++;
                end else if (nfr == 2) begin
                    rx1 = {rx1[14:0], c_sdata};
                end
                if (fall1 == 0) fall1 = k;
                else if (fall2 == 0) fall2 = k;
            end
            if (!c_sync) sync_low++;
            if (c_listo) begin
                listo_cnt++;
                if (listo_first == 0) listo_first = k;
            end
            if (rst_at > 0 && k == rst_at + 1) begin
                snap  = {c_sclk, c_sync, c_sdata, c_ocup, c_listo};
                reset = 1'b0;
            end
            if (rst_at > 0 && k == rst_at) reset = 1'b1;
            if (k == hold_until) begin
                if (sel) if1.inicio = 1'b0;
                else     if0.inicio = 1'b0;
            end
            if (k == chg_at) begin
                if (sel) if1.dato = chg_val[11:0];
                else     if0.dato = chg_val;
            end
            p_sclk = c_sclk;
            p_sync = c_sync;
        end
    endtask

    task automatic test_reset();
        logic [4:0] o0, o1;
        reset = 1'b1;
        if0.inicio = 1'b0; if0.dato = '0;
        if1.inicio = 1'b0; if1.dato = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            o0 = {if0.sclk, if0.sync_n, if0.sdata, if0.ocupado, if0.listo};
            o1 = {if1.sclk, if1.sync_n, if1.sdata, if1.ocupado, if1.listo};
            checks++;
            if (o0 !== 5'b11000) begin
                failures++;
                $display("FAIL idle_u0 cycle %0d: got %b expected 11000", i, o0);
            end
            checks++;
            if (o1 !== 5'b11000) begin
                failures++;
                $display("FAIL idle_u1 cycle %0d: got %b expected 11000", i, o1);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] rx0, rx1;
        logic [4:0]  snap;
        int nfr, st1, nb, sl, lc, lf, f1, f2;
        @(posedge clk); #1;
        if0.dato = 16'hA5C3; if0.inicio = 1'b1;
        capture(1'b0, 70, 1, 0, 16'h0, 0, rx0, rx1, nfr, st1, nb, sl, lc, lf, f1, f2, snap);
        checks++;
        if (rx0 !== 16'hA5C3) begin failures++; $display("FAIL single_rx: got %h expected a5c3", rx0); end
        checks++;
        if (nb !== 16) begin failures++; $display("FAIL single_nbits: got %0d expected 16", nb); end
        checks++;
        if (sl !== 64) begin failures++; $display("FAIL single_sync_low: got %0d expected 64", sl); end
        checks++;
        if (lc !== 1 || lf !== 65) begin
            failures++; $display("FAIL single_listo: got count %0d at %0d expected 1 at 65", lc, lf);
        end
        checks++;
        if (f1 !== 3 || f2 !== 7) begin
            failures++; $display("FAIL single_sclk_falls: got %0d,%0d expected 3,7", f1, f2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx0, rx1;
        logic [4:0]  snap;
        int nfr, st1, nb, sl, lc, lf, f1, f2;
        @(posedge clk); #1;
        if0.dato = 16'h0001; if0.inicio = 1'b1;
        capture(1'b0, 140, 67, 1, 16'hFFFF, 0, rx0, rx1, nfr, st1, nb, sl, lc, lf, f1, f2, snap);
        checks++;
        if (nfr !== 2 || st1 !== 67) begin
            failures++; $display("FAIL b2b_frames: got %0d frames second at %0d expected 2 at 67", nfr, st1);
        end
        checks++;
        if (rx0 !== 16'h0001) begin failures++; $display("FAIL b2b_rx0: got %h expected 0001", rx0); end
        checks++;
        if (rx1 !== 16'hFFFF) begin failures++; $display("FAIL b2b_rx1: got %h expected ffff", rx1); end
        checks++;
        if (lc !== 2 || lf !== 65) begin
            failures++; $display("FAIL b2b_listo: got count %0d first %0d expected 2 first 65", lc, lf);
        end
    endtask

    task automatic test_dato_change();
        logic [15:0] rx0, rx1;
        logic [4:0]  snap;
        int nfr, st1, nb, sl, lc, lf, f1, f2;
        @(posedge clk); #1;
        if0.dato = 16'h1234; if0.inicio = 1'b1;
        capture(1'b0, 70, 1, 10, 16'hFFFF, 0, rx0, rx1, nfr, st1, nb, sl, lc, lf, f1, f2, snap);
        checks++;
        if (rx0 !== 16'h1234) begin failures++; $display("FAIL dato_change_rx: got %h expected 1234", rx0); end
        checks++;
        if (lc !== 1) begin failures++; $display("FAIL dato_change_listo: got %0d expected 1", lc); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] rx0, rx1;
        logic [4:0]  snap;
        int nfr, st1, nb, sl, lc, lf, f1, f2;
        @(posedge clk); #1;
        if0.dato = 16'hFFFF; if0.inicio = 1'b1;
        capture(1'b0, 35, 1, 0, 16'h0, 30, rx0, rx1, nfr, st1, nb, sl, lc, lf, f1, f2, snap);
        checks++;
        if (snap !== 5'b11000) begin failures++; $display("FAIL reset_idle: got %b expected 11000", snap); end
        checks++;
        if (lc !== 0) begin failures++; $display("FAIL reset_no_listo: got %0d expected 0", lc); end
        if0.dato = 16'h5A3C; if0.inicio = 1'b1;
        capture(1'b0, 70, 1, 0, 16'h0, 0, rx0, rx1, nfr, st1, nb, sl, lc, lf, f1, f2, snap);
        checks++;
        if (rx0 !== 16'h5A3C) begin failures++; $display("FAIL reset_new_rx: got %h expected 5a3c", rx0); end
        checks++;
        if (lc !== 1 || lf !== 65) begin
            failures++; $display("FAIL reset_new_listo: got count %0d at %0d expected 1 at 65", lc, lf);
        end
    endtask

    task automatic test_div1();
        logic [15:0] rx0, rx1;
        logic [4:0]  snap;
        int nfr, st1, nb, sl, lc, lf, f1, f2;
        @(posedge clk); #1;
        if1.dato = 12'h800; if1.inicio = 1'b1;
        capture(1'b1, 30, 1, 0, 16'h0, 0, rx0, rx1, nfr, st1, nb, sl, lc, lf, f1, f2, snap);
        checks++;
        if (rx0 !== 16'h0800) begin failures++; $display("FAIL div1_rx: got %h expected 0800", rx0); end
        checks++;
        if (nb !== 12) begin failures++; $display("FAIL div1_nbits: got %0d expected 12", nb); end
        checks++;
        if (f1 !== 2 || f2 !== 4) begin
            failures++; $display("FAIL div1_sclk_period: got falls %0d,%0d expected 2,4", f1, f2);
        end
        checks++;
        if (lc !== 1 || lf !== 25) begin
            failures++; $display("FAIL div1_listo: got count %0d at %0d expected 1 at 25", lc, lf);
        end
        checks++;
        if (sl !== 24) begin failures++; $display("FAIL div1_sync_low: got %0d expected 24", sl); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_dato_change();
        test_mid_reset();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
